// File: rtl/sam_pkg.sv
// Shared definitions for the SAM convolution feeder and its downstream stage.
package sam_pkg;

    localparam int unsigned SAM_DATA_W      = 32;
    localparam int unsigned SAM_KERN_W      = 2;
    localparam int unsigned SAM_KERNEL_SIZE = 8;

    typedef enum logic [2:0] {
        LOAD,
        ARMED,
        START,
        STREAM,
        DONE
    } sam_state_e;

endpackage

// File: rtl/sam_frame_buffer.sv
// Simple dual-port frame store: one write port, one synchronous read port.
module sam_frame_buffer
    import sam_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Wr_En,
    input  logic [AW-1:0]         Wr_Addr,
    input  logic [SAM_DATA_W-1:0] Wr_Data,
    input  logic                  Rd_En,
    input  logic [AW-1:0]         Rd_Addr,
    output logic [SAM_DATA_W-1:0] Rd_Data
);

    logic [SAM_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (Wr_En) mem[Wr_Addr] <= Wr_Data;
        if (Rd_En) Rd_Data <= mem[Rd_Addr];
    end

endmodule

// File: rtl/sam_con_feeder.sv
// Buffers a frame and kernel, then resets the convolution stage and streams
// the frame to it gap-free with the kernel serialised on the first words.
module sam_con_feeder
    import sam_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = SAM_KERNEL_SIZE,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned AW          = $clog2(DEPTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [SAM_DATA_W-1:0] Wr_Data,
    input  logic                  Wr_Valid,
    input  logic                  Wr_Last,
    output logic                  Wr_Ready,
    input  logic [SAM_KERN_W-1:0] Kernel_Wr_Data,
    input  logic                  Kernel_Wr_Valid,
    input  logic                  Start,
    input  logic                  Flush,
    output logic [SAM_DATA_W-1:0] Data_Out,
    output logic [SAM_KERN_W-1:0] Kernel_Serial_Out,
    output logic                  Last_Data_Out,
    output logic                  Con_Rst,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned KW = $clog2(KERNEL_SIZE + 1);

    sam_state_e state, state_nxt;

    logic [CW-1:0]         frame_cnt, rd_ptr, rd_idx;
    logic [KW-1:0]         kern_cnt;
    logic                  rd_vld;
    logic [SAM_KERN_W-1:0] kernel [KERNEL_SIZE];
    logic [SAM_DATA_W-1:0] rd_data;

    logic                  flush_c, wr_acc_c, kern_acc_c, kern_err_c;
    logic                  start_ok_c, start_err_c, rd_issue_c, con_rst_c;
    logic [SAM_KERN_W-1:0] kser_c;

    always_ff @(posedge Clk) begin
        if (Rst) state <= LOAD;
        else     state <= state_nxt;
    end

    // Next state and per-cycle strobes; Flush overrides everything outside STREAM.
    always_comb begin
        state_nxt   = state;
        wr_acc_c    = 1'b0;
        kern_acc_c  = 1'b0;
        kern_err_c  = 1'b0;
        start_ok_c  = 1'b0;
        start_err_c = 1'b0;
        flush_c     = Flush && (state != STREAM);

        case (state)
            LOAD: begin
                if (Wr_Valid && Wr_Ready) begin
                    wr_acc_c = 1'b1;
                    if (Wr_Last || frame_cnt == CW'(DEPTH - 1)) state_nxt = ARMED;
                end
            end
            ARMED, DONE: begin
                if (Start) begin
                    if (kern_cnt == KW'(KERNEL_SIZE) && frame_cnt >= CW'(KERNEL_SIZE + 1)) begin
                        start_ok_c = 1'b1;
                        state_nxt  = START;
                    end else begin
                        start_err_c = 1'b1;
                    end
                end
            end
            START:   state_nxt = STREAM;
            STREAM:  if (Last_Data_Out) state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase

        if (Kernel_Wr_Valid && (state == LOAD || state == ARMED)) begin
            if (kern_cnt < KW'(KERNEL_SIZE)) kern_acc_c = 1'b1;
            else                             kern_err_c = 1'b1;
        end

        if (flush_c) begin
            state_nxt   = LOAD;
            wr_acc_c    = 1'b0;
            kern_acc_c  = 1'b0;
            kern_err_c  = 1'b0;
            start_ok_c  = 1'b0;
            start_err_c = 1'b0;
        end

        rd_issue_c = (state == START && state_nxt == STREAM) ||
                     (state == STREAM && rd_ptr < frame_cnt);
        con_rst_c  = flush_c || state == LOAD || state == ARMED || state == START;

        kser_c = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (rd_idx == CW'(i)) kser_c = kernel[i];
        end
    end

    always_ff @(posedge Clk) begin
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (kern_acc_c && kern_cnt == KW'(i)) kernel[i] <= Kernel_Wr_Data;
        end
    end

    sam_frame_buffer #(.DEPTH(DEPTH), .AW(AW)) u_frame_buffer (
        .Clk     (Clk),
        .Wr_En   (wr_acc_c),
        .Wr_Addr (frame_cnt[AW-1:0]),
        .Wr_Data (Wr_Data),
        .Rd_En   (rd_issue_c),
        .Rd_Addr (rd_ptr[AW-1:0]),
        .Rd_Data (rd_data)
    );

    // Counters, read pipeline and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            frame_cnt         <= '0;
            kern_cnt          <= '0;
            rd_ptr            <= '0;
            rd_idx            <= '0;
            rd_vld            <= 1'b0;
            Data_Out          <= '0;
            Kernel_Serial_Out <= '0;
            Last_Data_Out     <= 1'b0;
            Con_Rst           <= 1'b1;
            Wr_Ready          <= 1'b0;
            Busy              <= 1'b0;
            Done              <= 1'b0;
            Error             <= 1'b0;
        end else begin
            if (flush_c)       frame_cnt <= '0;
            else if (wr_acc_c) frame_cnt <= frame_cnt + CW'(1);

            if (flush_c)         kern_cnt <= '0;
            else if (kern_acc_c) kern_cnt <= kern_cnt + KW'(1);

            if (start_ok_c)      rd_ptr <= '0;
            else if (rd_issue_c) rd_ptr <= rd_ptr + CW'(1);

            rd_vld <= rd_issue_c;
            if (rd_issue_c) rd_idx <= rd_ptr;

            if (rd_vld) begin
                Data_Out          <= rd_data;
                Kernel_Serial_Out <= kser_c;
                Last_Data_Out     <= (rd_idx == frame_cnt - CW'(1));
            end else begin
                Kernel_Serial_Out <= '0;
                Last_Data_Out     <= 1'b0;
            end

            Con_Rst  <= con_rst_c;
            Wr_Ready <= (state_nxt == LOAD);
            Busy     <= (state_nxt == START) || (state_nxt == STREAM);
            Done     <= (state_nxt == DONE);
            Error    <= kern_err_c || start_err_c;
        end
    end

endmodule

// File: tb/tb_sam_con_feeder.sv
// Randomized self-checking bench for sam_con_feeder against a queue-based frame/kernel model.
module tb_sam_con_feeder;
    import sam_pkg::*;

    localparam int unsigned K     = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic                  Clk = 1'b0;
    logic                  Rst;
    logic [SAM_DATA_W-1:0] Wr_Data;
    logic                  Wr_Valid, Wr_Last, Wr_Ready;
    logic [SAM_KERN_W-1:0] Kernel_Wr_Data;
    logic                  Kernel_Wr_Valid, Start, Flush;
    logic [SAM_DATA_W-1:0] Data_Out;
    logic [SAM_KERN_W-1:0] Kernel_Serial_Out;
    logic                  Last_Data_Out, Con_Rst, Busy, Done, Error;

    sam_con_feeder #(.KERNEL_SIZE(K), .DEPTH(DEPTH), .AW(AW)) dut (
        .Clk               (Clk),
        .Rst               (Rst),
        .Wr_Data           (Wr_Data),
        .Wr_Valid          (Wr_Valid),
        .Wr_Last           (Wr_Last),
        .Wr_Ready          (Wr_Ready),
        .Kernel_Wr_Data    (Kernel_Wr_Data),
        .Kernel_Wr_Valid   (Kernel_Wr_Valid),
        .Start             (Start),
        .Flush             (Flush),
        .Data_Out          (Data_Out),
        .Kernel_Serial_Out (Kernel_Serial_Out),
        .Last_Data_Out     (Last_Data_Out),
        .Con_Rst           (Con_Rst),
        .Busy              (Busy),
        .Done              (Done),
        .Error             (Error)
    );

    always #5 Clk = ~Clk;

    typedef enum {M_LOAD, M_ARMED, M_DONE} mphase_e;
    mphase_e     mph;
    logic [31:0] fq [$];
    logic [1:0]  kq [$];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_clear();
        fq.delete();
        kq.delete();
        mph = M_LOAD;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, Data_Out, 0);
        chk({tag, "_kser"}, 32'(Kernel_Serial_Out), 0);
        chk({tag, "_last"}, 32'(Last_Data_Out), 0);
        chk({tag, "_conrst"}, 32'(Con_Rst), 1);
        chk({tag, "_rdy"}, 32'(Wr_Ready), 0);
        chk({tag, "_busy"}, 32'(Busy), 0);
        chk({tag, "_done"}, 32'(Done), 0);
        chk({tag, "_err"}, 32'(Error), 0);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        tick();
        chk_reset_outputs("rst");
        Rst = 1'b0;
        tick();
        chk("rst_rdy_after", 32'(Wr_Ready), 1);
        model_clear();
    endtask

    task automatic wr_word(input logic [31:0] d, input logic last);
        Wr_Data = d; Wr_Valid = 1'b1; Wr_Last = last;
        tick();
        Wr_Valid = 1'b0; Wr_Last = 1'b0;
        if (mph == M_LOAD) begin
            fq.push_back(d);
            if (last || fq.size() == DEPTH) mph = M_ARMED;
        end
        chk("wr_ready", 32'(Wr_Ready), 32'(mph == M_LOAD));
    endtask

    task automatic wr_kern(input logic [1:0] d);
        bit err = 1'b0;
        Kernel_Wr_Data = d; Kernel_Wr_Valid = 1'b1;
        tick();
        Kernel_Wr_Valid = 1'b0;
        if (mph != M_DONE) begin
            if (kq.size() < K) kq.push_back(d);
            else               err = 1'b1;
        end
        chk("kern_err", 32'(Error), 32'(err));
    endtask

    task automatic do_flush(input logic with_start);
        Flush = 1'b1; Start = with_start;
        tick();
        Flush = 1'b0; Start = 1'b0;
        model_clear();
        chk("flush_conrst", 32'(Con_Rst), 1);
        chk("flush_rdy", 32'(Wr_Ready), 1);
        chk("flush_busy", 32'(Busy), 0);
        chk("flush_err", 32'(Error), 0);
    endtask

    // Request a stream; rst_at >= 0 asserts Rst in place of that word.
    task automatic do_start(input int rst_at);
        bit ok, from_done;
        ok        = (mph != M_LOAD) && kq.size() == K && fq.size() >= K + 1;
        from_done = (mph == M_DONE);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_err", 32'(Error), 32'((mph != M_LOAD) && !ok));
        chk("start_busy", 32'(Busy), 32'(ok));
        if (!ok) begin
            chk("rej_conrst", 32'(Con_Rst), 32'(!from_done));
            chk("rej_done", 32'(Done), 32'(from_done));
            return;
        end
        chk("e0_conrst", 32'(Con_Rst), 32'(!from_done));
        tick();
        chk("e1_conrst", 32'(Con_Rst), 1);
        chk("e1_data_idle", 32'(Last_Data_Out), 0);
        for (int i = 0; i < fq.size(); i++) begin
            Flush = ($urandom_range(0, 7) == 0);
            if (i == rst_at) Rst = 1'b1;
            tick();
            Flush = 1'b0;
            if (i == rst_at) begin
                chk_reset_outputs("midrst");
                Rst = 1'b0;
                tick();
                chk("midrst_rdy", 32'(Wr_Ready), 1);
                model_clear();
                return;
            end
            chk("s_data", Data_Out, fq[i]);
            chk("s_kser", 32'(Kernel_Serial_Out), (i < K) ? 32'(kq[i]) : 32'd0);
            chk("s_last", 32'(Last_Data_Out), 32'(i == fq.size() - 1));
            chk("s_conrst", 32'(Con_Rst), 0);
            chk("s_busy", 32'(Busy), 1);
            chk("s_done", 32'(Done), 0);
        end
        Flush = ($urandom_range(0, 3) == 0);
        tick();
        Flush = 1'b0;
        chk("d_done", 32'(Done), 1);
        chk("d_busy", 32'(Busy), 0);
        chk("d_last", 32'(Last_Data_Out), 0);
        chk("d_kser", 32'(Kernel_Serial_Out), 0);
        chk("d_data", Data_Out, fq[$]);
        chk("d_conrst", 32'(Con_Rst), 0);
        mph = M_DONE;
    endtask

    initial begin
        int n, nk;
        logic [1:0] kdir [8];
        Rst = 1'b1; Wr_Data = '0; Wr_Valid = 1'b0; Wr_Last = 1'b0;
        Kernel_Wr_Data = '0; Kernel_Wr_Valid = 1'b0; Start = 1'b0; Flush = 1'b0;
        model_clear();
        do_reset();

        // Reference frame 1..12 with kernel 0,1,2,3,0,1,2,3, then replay.
        kdir = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 8; i++) wr_kern(kdir[i]);
        for (int i = 1; i <= 12; i++) wr_word(32'(i), i == 12);
        do_start(-1);
        do_start(-1);
        do_flush(1'b1);

        // Too-short frame, then too few kernel entries.
        for (int i = 0; i < 8; i++) wr_kern(2'($urandom));
        for (int i = 0; i < 8; i++) wr_word($urandom, i == 7);
        do_start(-1);
        do_flush(1'b0);
        for (int i = 0; i < 7; i++) wr_kern(2'($urandom));
        for (int i = 0; i < 9; i++) wr_word($urandom, i == 8);
        do_start(-1);
        wr_kern(2'($urandom));
        do_start(-1);

        // Full depth without Wr_Last, rejected 17th word, rejected 9th kernel entry.
        do_flush(1'b0);
        for (int i = 0; i < 8; i++) wr_kern(2'($urandom));
        for (int i = 0; i < DEPTH; i++) wr_word($urandom, 1'b0);
        wr_word(32'hDEAD_BEEF, 1'b1);
        wr_kern(2'($urandom));
        do_start(-1);
        do_start(5);
        do_start(-1);

        // Randomized frames and kernels.
        for (int r = 0; r < 30; r++) begin
            do_flush(1'b0);
            nk = $urandom_range(7, 9);
            n  = $urandom_range(6, DEPTH);
            for (int i = 0; i < nk; i++) wr_kern(2'($urandom));
            for (int i = 0; i < n; i++)
                wr_word($urandom, (i == n - 1) && (n < DEPTH || $urandom_range(0, 1) == 1));
            if ($urandom_range(0, 1) == 1) wr_word($urandom, 1'b1);
            do_start(-1);
            if (mph == M_DONE && $urandom_range(0, 1) == 1) do_start(-1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
